max_tile_tracker: RTL and testbench
===================================

# max_tile_tracker

Scans the 16-cell 2048 board one cell per clock and produces the 12-bit largest-tile value consumed by the four-digit seven-segment display controller. It sits directly upstream of the display: the board/game logic requests a scan after every move, and this block's registered `value` drives the display's `value` input. A game-over condition overrides the result with 0, which the display renders as "LOSE".

## Interface
- `CELLS`, 16: number of board cells scanned.
- `EXP_W`, 4: width of one cell exponent (0 = empty, k = tile 2^k).
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `board_exp`  in  CELLS*EXP_W  packed board; cell i at `[EXP_W*i +: EXP_W]`.
- `game_over`  in  1  level from game logic; sampled in UPDATE.
- `scan_req`  in  1  single-cycle request; honoured only in IDLE.
- `value`  out  12  largest tile (2..2048) or 0 for lose.
- `busy`  out  1  high in SCAN and UPDATE.
- `done`  out  1  one-cycle pulse when `value` is refreshed.
- `err`  out  1  sticky invalid-exponent flag (see Configuration).

## Operation
- FSM states: IDLE, SCAN, UPDATE.
- IDLE + `scan_req`=1: snapshot `board_exp` into internal register, clear `max_exp`, `idx`=0, go to SCAN. `board_exp` changes after capture have no effect.
- SCAN: each cycle compare snapshot cell `idx` with `max_exp`; keep larger (ties leave it unchanged); `idx`++. After cell 15 (`idx` wraps 15->0), go to UPDATE.
- UPDATE (one cycle), result registered on its closing edge:
  - `game_over`=1: `value` <= 12'd0.
  - else `max_exp`=0 (empty board): `value` unchanged.
  - else `value` <= 12'd1 << `max_exp`.
  - `done` <= 1 in all three cases; return to IDLE.
- `scan_req` in SCAN or UPDATE: ignored; not queued.
- Legal exponents 1..11; 12..15 handled per Configuration.
- Reset (any state, asynchronous): state IDLE, `idx`=0, `max_exp`=0, snapshot=0, `value`=12'd2, `busy`=0, `done`=0, `err`=0. A reset mid-scan discards the scan; no `done`.

## Timing
- `scan_req` sampled at edge E0; `busy`=1 after E0.
- Cell i evaluated at edge E(i+1), i=0..15; state=UPDATE after E16.
- `value`/`done` update at E17; `busy`=0 and state IDLE after E17; `done` low after E18.
- Request-to-result latency 17 cycles; earliest next accepted `scan_req` is at E18 (18-cycle throughput).
- `value` is fully registered; it is stable across the display's slow multiplex clock except for single-edge changes at `done`.

## Configuration
- Macro `MAX_TILE_ERR_EN`.
- Defined: cells with exponent > 11 are excluded from the max, and `err` is set and held until reset.
- Undefined: exponents > 11 saturate to 11 (tile 2048) before comparison; `err` is tied 0.

## Structure
- Package `max_tile_pkg`: `CELLS`, `EXP_W`, `EXP_MAX`=11, the FSM state enum, and constants `VALUE_LOSE`=12'd0 and `VALUE_RST`=12'd2.
- One sub-module, `exp_to_value`: combinational mapping from a 4-bit exponent to the 12-bit value, with saturation/validity per the macro. It is instantiated once on the `max_exp` path.

## Test plan
- Reset check: assert `rst`=0 mid-scan, then release -> `value`=2, `busy`=0, `done`=0, `err`=0, and no `done` from the aborted scan.
- Board with cell 7=10 and all others ≤ 3, `scan_req` at E0 -> `value`=1024 at E17, `done` high exactly one cycle, `busy` high E0..E17.
- `game_over`=1 during UPDATE with a board max of 2048 -> `value`=0 (display shows LOSE); a following scan with `game_over`=0 -> `value`=2048.
- All-empty board after a previous result of 64 -> `value` stays 64 and `done` still pulses at E17.
- `scan_req` held high continuously, and `board_exp` altered at E5 -> scans start at E0 and E18 only; the first result reflects the E0 snapshot.
- Cell 15=13, all others 5: with `MAX_TILE_ERR_EN` -> `value`=32 and `err`=1 (sticky); without the macro -> `value`=2048 and `err`=0.

Source files
------------

// File: rtl/max_tile_pkg.sv
// -----------------------------------------------------------------------------
// max_tile_pkg
//
// Purpose : Shared constants, FSM state type and exponent helper for the
//           2048 largest-tile tracker (max_tile_tracker / exp_to_value).
//
// Contents:
//   CELLS       number of board cells scanned (16)
//   EXP_W       width of one cell exponent (0 = empty, k = tile 2^k)
//   IDX_W       width of the cell index counter
//   VAL_W       width of the display value (12)
//   EXP_MAX     largest legal exponent (11 -> tile 2048)
//   VALUE_LOSE  value shown for game over (display renders "LOSE")
//   VALUE_RST   value presented after reset (tile 2)
//   state_t     IDLE / SCAN / UPDATE
//   sat_exp()   clamp an exponent to EXP_MAX
//
// Configuration: macro MAX_TILE_ERR_EN selects exclude-and-flag handling of
//                exponents above EXP_MAX; when undefined they saturate.
// -----------------------------------------------------------------------------
package max_tile_pkg;

  localparam int CELLS = 16;
  localparam int EXP_W = 4;
  localparam int IDX_W = $clog2(CELLS);
  localparam int VAL_W = 12;

  localparam logic [EXP_W-1:0] EXP_MAX    = 4'd11;
  localparam logic [VAL_W-1:0] VALUE_LOSE = 12'd0;
  localparam logic [VAL_W-1:0] VALUE_RST  = 12'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  // Clamp an exponent so that anything above the 2048 tile reads as 2048.
  function automatic logic [EXP_W-1:0] sat_exp(input logic [EXP_W-1:0] e);
    return (e > EXP_MAX) ? EXP_MAX : e;
  endfunction

endpackage

// File: rtl/exp_to_value.sv
// -----------------------------------------------------------------------------
// exp_to_value
//
// Purpose : Combinational map from a tile exponent to the 12-bit tile value
//           (2^exp) that the seven-segment display controller consumes.
//
// Ports   :
//   tile_exp    in  EXP_W  tile exponent
//   tile_value  out VAL_W  1 << tile_exp
//
// Configuration (macro MAX_TILE_ERR_EN):
//   defined   : exponents above EXP_MAX are invalid and map to 0
//   undefined : exponents above EXP_MAX saturate to EXP_MAX (2048)
// -----------------------------------------------------------------------------
module exp_to_value
  import max_tile_pkg::*;
(
  input  logic [EXP_W-1:0] tile_exp,
  output logic [VAL_W-1:0] tile_value
);

  always_comb begin
    tile_value = '0;
`ifdef MAX_TILE_ERR_EN
    if (tile_exp <= EXP_MAX) begin
      tile_value = VAL_W'(1) << tile_exp;
    end
`else
    tile_value = VAL_W'(1) << sat_exp(tile_exp);
`endif
  end

endmodule

// File: rtl/max_tile_tracker.sv
// -----------------------------------------------------------------------------
// max_tile_tracker
//
// Purpose : On request, snapshots the 16-cell 2048 board and scans it one
//           cell per clock to find the largest tile exponent, then registers
//           the tile value (or 0 on game over) for the seven-segment display.
//           Request-to-result latency is 17 cycles; a new request can be
//           accepted every 18 cycles.
//
// Ports   :
//   clk        in   1            system clock
//   rst        in   1            asynchronous, active-low reset
//   board_exp  in   CELLS*EXP_W  packed board, cell i at [EXP_W*i +: EXP_W]
//   game_over  in   1            level, sampled in UPDATE; forces value 0
//   scan_req   in   1            start a scan; honoured only in IDLE
//   value      out  12           largest tile (2..2048) or 0 for lose
//   busy       out  1            high while scanning / updating
//   done       out  1            one-cycle pulse when value is refreshed
//   err        out  1            sticky invalid-exponent flag
//
// Configuration (macro MAX_TILE_ERR_EN):
//   defined   : cells with exponent > 11 are skipped and set err (sticky)
//   undefined : cells with exponent > 11 count as 11; err tied 0
// -----------------------------------------------------------------------------
module max_tile_tracker
  import max_tile_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CELLS*EXP_W-1:0] board_exp,
  input  logic                   game_over,
  input  logic                   scan_req,
  output logic [VAL_W-1:0]       value,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CELLS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [EXP_W-1:0] max_exp;
  logic [EXP_W-1:0] snap [CELLS];

  logic [EXP_W-1:0] cell_raw;
  logic [EXP_W-1:0] cell_exp;
  logic [VAL_W-1:0] max_val;

  assign cell_raw = snap[idx];

`ifdef MAX_TILE_ERR_EN
  logic cell_bad;

  // An out-of-range cell is treated as empty so it can never win the compare.
  assign cell_bad = (cell_raw > EXP_MAX);
  assign cell_exp = cell_bad ? '0 : cell_raw;
`else
  assign cell_exp = sat_exp(cell_raw);
  assign err      = 1'b0;
`endif

  exp_to_value u_exp_to_value (
    .tile_exp   (max_exp),
    .tile_value (max_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      max_exp <= '0;
      for (int i = 0; i < CELLS; i++) begin
        snap[i] <= '0;
      end
      value   <= VALUE_RST;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef MAX_TILE_ERR_EN
      err     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (scan_req) begin
            // Snapshot so the board may change freely during the scan.
            for (int i = 0; i < CELLS; i++) begin
              snap[i] <= board_exp[EXP_W*i +: EXP_W];
            end
            max_exp <= '0;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          // Strictly greater: ties keep the current maximum.
          if (cell_exp > max_exp) begin
            max_exp <= cell_exp;
          end
`ifdef MAX_TILE_ERR_EN
          if (cell_bad) begin
            err <= 1'b1;
          end
`endif
          idx <= idx + 1'b1;
          if (idx == IDX_LAST) begin
            state <= ST_UPDATE;
          end
        end

        ST_UPDATE: begin
          // Empty board leaves the previous value on the display.
          if (game_over) begin
            value <= VALUE_LOSE;
          end else if (max_exp != '0) begin
            value <= max_val;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_tile_tracker.sv
// -----------------------------------------------------------------------------
// tb_max_tile_tracker
//
// Self-checking bench for max_tile_tracker. A behavioural model computes the
// expected display value and error flag directly from the board contents.
// Honours MAX_TILE_ERR_EN the same way as the design build.
// -----------------------------------------------------------------------------
module tb_max_tile_tracker;

  logic        clk;
  logic        rst;
  logic [63:0] board_exp;
  logic        game_over;
  logic        scan_req;
  logic [11:0] value;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [3:0]  cells [16];
  logic [11:0] m_value;
  logic        m_err;

  max_tile_tracker dut (
    .clk       (clk),
    .rst       (rst),
    .board_exp (board_exp),
    .game_over (game_over),
    .scan_req  (scan_req),
    .value     (value),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic pack_board();
    for (int i = 0; i < 16; i++) board_exp[4*i +: 4] = cells[i];
  endtask

  // Reference: largest legal tile on the board, game over wins, empty keeps.
  task automatic model_scan(input bit go);
    int m;
    int e;
    m = 0;
    for (int i = 0; i < 16; i++) begin
      e = int'(cells[i]);
      if (e > 11) begin
`ifdef MAX_TILE_ERR_EN
        m_err = 1'b1;
        e = 0;
`else
        e = 11;
`endif
      end
      if (e > m) m = e;
    end
    if (go) m_value = 12'd0;
    else if (m != 0) m_value = 12'(1 << m);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete request; checks timing, result and the done pulse width.
  task automatic run_scan(input bit go, input string tag);
    int  n;
    bit  busy_ok;
    pack_board();
    game_over = go;
    scan_req  = 1'b1;
    tick();                         // E0
    scan_req = 1'b0;
    model_scan(go);
    chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
    busy_ok = 1'b1;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    chk({tag, "_latency"}, 32'(n), 32'd17);
    chk({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
    chk({tag, "_value"}, 32'(value), 32'(m_value));
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    tick();                         // E18
    chk({tag, "_done_width"}, 32'(done), 32'd0);
    game_over = 1'b0;
  endtask

  initial begin
    int          c;
    int          ndone;
    int          done_at [$];
    logic [11:0] val_at [$];
    logic [11:0] exp_a;
    logic [11:0] exp_b;
    int          busy17;
    int          busy18;

    rst       = 1'b0;
    game_over = 1'b0;
    scan_req  = 1'b0;
    for (int i = 0; i < 16; i++) cells[i] = 4'd0;
    pack_board();
    m_value = 12'd2;
    m_err   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_value", 32'(value), 32'd2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    tick();

    // Cell 7 = 10, others <= 3
    for (int i = 0; i < 16; i++) cells[i] = 4'($urandom_range(0, 3));
    cells[7] = 4'd10;
    run_scan(1'b0, "t1024");
    chk("t1024_const", 32'(value), 32'd1024);

    // Reset in the middle of a scan
    for (int i = 0; i < 16; i++) cells[i] = 4'd9;
    pack_board();
    scan_req = 1'b1;
    tick();
    scan_req = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    chk("midrst_value", 32'(value), 32'd2);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    m_value = 12'd2;
    m_err   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    chk("midrst_value_hold", 32'(value), 32'd2);

    // Game over with a 2048 on the board, then a normal scan
    for (int i = 0; i < 16; i++) cells[i] = 4'($urandom_range(1, 10));
    cells[3] = 4'd11;
    run_scan(1'b1, "lose");
    chk("lose_const", 32'(value), 32'd0);
    run_scan(1'b0, "t2048");
    chk("t2048_const", 32'(value), 32'd2048);

    // Empty board keeps the previous result
    for (int i = 0; i < 16; i++) cells[i] = 4'($urandom_range(0, 5));
    cells[12] = 4'd6;
    run_scan(1'b0, "t64");
    for (int i = 0; i < 16; i++) cells[i] = 4'd0;
    run_scan(1'b0, "empty");
    chk("empty_const", 32'(value), 32'd64);

    // scan_req held high; board altered before E5
    for (int i = 0; i < 16; i++) cells[i] = 4'($urandom_range(0, 4));
    cells[0] = 4'd8;
    pack_board();
    model_scan(1'b0);
    exp_a = m_value;
    scan_req = 1'b1;
    tick();                         // E0
    busy17 = -1;
    busy18 = -1;
    for (c = 1; c <= 45; c++) begin
      tick();
      if (c == 4) begin
        for (int i = 0; i < 16; i++) cells[i] = 4'($urandom_range(0, 4));
        cells[9] = 4'd7;
        pack_board();
        model_scan(1'b0);
        exp_b = m_value;
      end
      if (c == 17) busy17 = int'(busy);
      if (c == 18) begin
        busy18 = int'(busy);
        scan_req = 1'b0;
      end
      if (done) begin
        done_at.push_back(c);
        val_at.push_back(value);
      end
    end
    chk("held_ndone", 32'(done_at.size()), 32'd2);
    chk("held_busy_e17", 32'(busy17), 32'd0);
    chk("held_busy_e18", 32'(busy18), 32'd1);
    if (done_at.size() >= 2) begin
      chk("held_done1_at", 32'(done_at[0]), 32'd17);
      chk("held_value1", 32'(val_at[0]), 32'(exp_a));
      chk("held_done2_at", 32'(done_at[1]), 32'd35);
      chk("held_value2", 32'(val_at[1]), 32'(exp_b));
    end

    // Out-of-range exponent: cell 15 = 13, others 5
    for (int i = 0; i < 16; i++) cells[i] = 4'd5;
    cells[15] = 4'd13;
    run_scan(1'b0, "inv");
`ifdef MAX_TILE_ERR_EN
    chk("inv_const_value", 32'(value), 32'd32);
    chk("inv_const_err", 32'(err), 32'd1);
`else
    chk("inv_const_value", 32'(value), 32'd2048);
    chk("inv_const_err", 32'(err), 32'd0);
`endif

    // Randomized scans
    for (int t = 0; t < 24; t++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      for (int i = 0; i < 16; i++) begin
        if (kind == 0) cells[i] = 4'd0;
        else if ($urandom_range(0, 19) == 0) cells[i] = 4'($urandom_range(12, 15));
        else cells[i] = 4'($urandom_range(0, 11));
      end
      run_scan($urandom_range(0, 7) == 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
